// File: rtl/mc_pkg.sv
// Shared constants and types for the microcontroller memory subsystem.
package mc_pkg;

  localparam int WORD_W          = 16;
  localparam int WAIT_CYCLES_DEF = 2;
  localparam int CNT_W           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM: registered read, write on rising edge.
// Contents are deliberately not reset.
module mem_array #(
  parameter int ADDR_W = 8,
  parameter int WORD_W = mc_pkg::WORD_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [2**ADDR_W];

  // Write port and registered read port (read returns pre-write contents).
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/mem_unit.sv
// Data memory with MAR/MDR and a wait-state access sequencer.
// An access latches address, data and direction at its start edge, counts
// WAIT_CYCLES, performs the RAM access, then raises MFC until memEN drops.
module mem_unit
  import mc_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WORD_W      = mc_pkg::WORD_W,
  parameter int WAIT_CYCLES = mc_pkg::WAIT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] bus_in,
  input  logic              marIn,
  input  logic              mdrWriteEN,
  input  logic              mdrReadEN,
  input  logic              mdrOut,
  input  logic              memEN,
  input  logic              RW,
  output logic [WORD_W-1:0] bus_out,
  output logic              bus_drive,
  output logic              MFC,
  output logic              busy
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              rw_q, rw_d;
  logic              mfc_q, mfc_d;
  logic [WORD_W-1:0] rdbuf_q, rdbuf_d;
  logic [WORD_W-1:0] mar_q, mar_d;
  logic [WORD_W-1:0] mdr_q, mdr_d;

  logic              ram_we_s;
  logic [ADDR_W-1:0] ram_addr_s;
  logic [WORD_W-1:0] ram_rdata_s;
  logic              unused_mar_s;

  // Upper MAR bits only wrap the address; they do not reach the RAM.
  assign unused_mar_s = ^mar_q;

  // While idle the RAM pre-reads the MAR target so that the registered read
  // data is ready at the completing edge even with zero wait states; once an
  // access starts it sees only the latched address.
  assign ram_addr_s = (state_q == IDLE) ? mar_q[ADDR_W-1:0] : addr_q;

  mem_array #(
    .ADDR_W (ADDR_W),
    .WORD_W (WORD_W)
  ) u_mem_array (
    .clk   (clk),
    .we    (ram_we_s),
    .addr  (ram_addr_s),
    .wdata (wdata_q),
    .rdata (ram_rdata_s)
  );

  // State and datapath registers; async reset drops any in-flight access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      addr_q  <= {ADDR_W{1'b0}};
      wdata_q <= {WORD_W{1'b0}};
      rw_q    <= 1'b0;
      mfc_q   <= 1'b0;
      rdbuf_q <= {WORD_W{1'b0}};
      mar_q   <= {WORD_W{1'b0}};
      mdr_q   <= {WORD_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      mfc_q   <= mfc_d;
      rdbuf_q <= rdbuf_d;
      mar_q   <= mar_d;
      mdr_q   <= mdr_d;
    end
  end

  // Access sequencer: next state, counter, latched operands, MFC, RAM write.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rw_d     = rw_q;
    mfc_d    = mfc_q;
    rdbuf_d  = rdbuf_q;
    ram_we_s = 1'b0;

    case (state_q)
      IDLE: begin
        mfc_d = 1'b0;
        if (memEN) begin
          addr_d  = mar_q[ADDR_W-1:0];
          rw_d    = RW;
          wdata_d = mdr_q;
          cnt_d   = WAIT_INIT;
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (!memEN) begin
          // Abort: nothing is written and rdbuf keeps its old value.
          mfc_d   = 1'b0;
          state_d = IDLE;
        end else if (cnt_q != {CNT_W{1'b0}}) begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          if (rw_q) begin
            rdbuf_d = ram_rdata_s;
          end else begin
            ram_we_s = 1'b1;
          end
          mfc_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (memEN) begin
          mfc_d = 1'b1;
        end else begin
          mfc_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        mfc_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // MAR/MDR loads from the register bus; a bus write beats a read-buffer load.
  always_comb begin
    mar_d = mar_q;
    mdr_d = mdr_q;
    if (marIn) begin
      mar_d = bus_in;
    end else begin
      mar_d = mar_q;
    end
    if (mdrWriteEN) begin
      mdr_d = bus_in;
    end else if (mdrReadEN) begin
      mdr_d = rdbuf_q;
    end else begin
      mdr_d = mdr_q;
    end
  end

  assign bus_out   = mdrOut ? mdr_q : {WORD_W{1'b0}};
  assign bus_drive = mdrOut;
  assign MFC       = mfc_q;
  assign busy      = (state_q == BUSY);

endmodule

// File: tb/tb_mem_unit.sv
// Directed self-checking bench for mem_unit (WAIT_CYCLES=2 and 0 builds).
module tb_mem_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bus_in;
  logic        marIn, mdrWriteEN, mdrReadEN, mdrOut, memEN, RW;
  logic [15:0] bus_out;
  logic        bus_drive, MFC, busy;

  logic [15:0] z_bus_in;
  logic        z_marIn, z_mdrWriteEN, z_mdrReadEN, z_mdrOut, z_memEN, z_RW;
  logic [15:0] z_bus_out;
  logic        z_bus_drive, z_MFC, z_busy;

  int checks = 0;
  int errors = 0;
  int lat;
  int held;
  logic [15:0] val;

  always #5 clk = ~clk;

  mem_unit #(.ADDR_W(8), .WORD_W(16), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .bus_in(bus_in), .marIn(marIn),
    .mdrWriteEN(mdrWriteEN), .mdrReadEN(mdrReadEN), .mdrOut(mdrOut),
    .memEN(memEN), .RW(RW), .bus_out(bus_out), .bus_drive(bus_drive),
    .MFC(MFC), .busy(busy)
  );

  mem_unit #(.ADDR_W(8), .WORD_W(16), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .rst(rst), .bus_in(z_bus_in), .marIn(z_marIn),
    .mdrWriteEN(z_mdrWriteEN), .mdrReadEN(z_mdrReadEN), .mdrOut(z_mdrOut),
    .memEN(z_memEN), .RW(z_RW), .bus_out(z_bus_out), .bus_drive(z_bus_drive),
    .MFC(z_MFC), .busy(z_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_mar(input logic [15:0] v);
    bus_in = v; marIn = 1'b1; tick(); marIn = 1'b0;
  endtask

  task automatic load_mdr(input logic [15:0] v);
    bus_in = v; mdrWriteEN = 1'b1; tick(); mdrWriteEN = 1'b0;
  endtask

  // Ticks until MFC is seen, bounded; returns -1 on timeout.
  task automatic wait_mfc(output int n);
    n = 0;
    while (MFC !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (MFC !== 1'b1) n = -1;
  endtask

  // Raises memEN, takes E0, returns edges from E0 to MFC; memEN left high.
  task automatic run_access(input logic rw, output int n);
    memEN = 1'b1; RW = rw;
    tick();
    wait_mfc(n);
  endtask

  task automatic write_word(input string tag, input logic [15:0] a, input logic [15:0] d);
    int n;
    load_mar(a);
    load_mdr(d);
    run_access(1'b0, n);
    chk(tag, n, 3);
    memEN = 1'b0;
    tick();
  endtask

  // Read access, load MDR from rdbuf while MFC=1, drive MDR onto the bus.
  task automatic read_word(input string tag, input logic [15:0] a, output logic [15:0] v);
    int n;
    load_mar(a);
    run_access(1'b1, n);
    chk(tag, n, 3);
    mdrReadEN = 1'b1; memEN = 1'b0;
    tick();
    mdrReadEN = 1'b0; mdrOut = 1'b1;
    #1 v = bus_out;
    mdrOut = 1'b0;
  endtask

  // Loads MDR from rdbuf outside any access and returns it via the bus.
  task automatic peek_rdbuf(output logic [15:0] v);
    mdrReadEN = 1'b1;
    tick();
    mdrReadEN = 1'b0; mdrOut = 1'b1;
    #1 v = bus_out;
    mdrOut = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus_in = 16'h0000; marIn = 1'b0; mdrWriteEN = 1'b0; mdrReadEN = 1'b0;
    mdrOut = 1'b0; memEN = 1'b0; RW = 1'b0;
    z_bus_in = 16'h0000; z_marIn = 1'b0; z_mdrWriteEN = 1'b0; z_mdrReadEN = 1'b0;
    z_mdrOut = 1'b0; z_memEN = 1'b0; z_RW = 1'b0;

    // Reset state
    #12;
    mdrOut = 1'b1;
    #1;
    chk("rst_mfc", MFC, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_bus_out", bus_out, 16'h0000);
    chk("rst_bus_drive_1", bus_drive, 1'b1);
    mdrOut = 1'b0;
    #1;
    chk("rst_bus_drive_0", bus_drive, 1'b0);
    rst = 1'b0;
    tick();

    // Write then read
    load_mar(16'h0005);
    load_mdr(16'hBEEF);
    run_access(1'b0, lat);
    chk("t1_wr_latency", lat, 3);
    chk("t1_busy_in_done", busy, 1'b0);
    memEN = 1'b0;
    tick();
    chk("t1_mfc_fall", MFC, 1'b0);
    load_mdr(16'h0000);
    read_word("t1_rd_latency", 16'h0005, val);
    chk("t1_read_data", val, 16'hBEEF);

    // Abort mid-BUSY
    write_word("t2_pre_wr_latency", 16'h0007, 16'hAAAA);
    load_mar(16'h0007);
    load_mdr(16'h1234);
    memEN = 1'b1; RW = 1'b0;
    tick();
    tick();
    chk("t2_busy", busy, 1'b1);
    memEN = 1'b0;
    tick();
    chk("t2_abort_idle", busy, 1'b0);
    repeat (4) tick();
    chk("t2_abort_mfc", MFC, 1'b0);
    load_mdr(16'h0000);
    peek_rdbuf(val);
    chk("t2_rdbuf_kept", val, 16'hBEEF);
    read_word("t2_rd_latency", 16'h0007, val);
    chk("t2_read_after_abort", val, 16'hAAAA);

    // Address wrap
    write_word("t3_wr_latency", 16'h0103, 16'h00C3);
    read_word("t3_rd_latency", 16'h0003, val);
    chk("t3_wrap_data", val, 16'h00C3);

    // Latched operands: MAR/MDR/RW changed during BUSY
    load_mar(16'h0002);
    load_mdr(16'h1111);
    memEN = 1'b1; RW = 1'b0;
    tick();
    bus_in = 16'h2222; mdrWriteEN = 1'b1; marIn = 1'b1; RW = 1'b1;
    tick();
    mdrWriteEN = 1'b0; marIn = 1'b0;
    wait_mfc(lat);
    chk("t4_latency", lat + 1, 3);
    memEN = 1'b0; RW = 1'b0;
    tick();
    peek_rdbuf(val);
    chk("t4_was_write", val, 16'h00C3);
    read_word("t4_rd_latency", 16'h0002, val);
    chk("t4_latched_data", val, 16'h1111);

    // MDR load priority
    bus_in = 16'h5A5A; mdrWriteEN = 1'b1; mdrReadEN = 1'b1;
    tick();
    mdrWriteEN = 1'b0; mdrReadEN = 1'b0; mdrOut = 1'b1;
    #1 chk("t5_mdr_priority", bus_out, 16'h5A5A);
    mdrOut = 1'b0;

    // MFC hold in DONE
    load_mar(16'h0010);
    run_access(1'b0, lat);
    chk("t5_wr_latency", lat, 3);
    held = 0;
    repeat (5) begin
      tick();
      if (MFC === 1'b1) held++;
    end
    chk("t5_mfc_held", held, 5);
    memEN = 1'b0;
    #1 chk("t5_mfc_before_edge", MFC, 1'b1);
    tick();
    chk("t5_mfc_fall", MFC, 1'b0);
    read_word("t5_rd_latency", 16'h0010, val);
    chk("t5_hold_data", val, 16'h5A5A);

    // Async reset while BUSY
    load_mar(16'h0007);
    load_mdr(16'h7777);
    memEN = 1'b1; RW = 1'b0;
    tick();
    tick();
    chk("t6_busy_before_rst", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_mfc", MFC, 1'b0);
    memEN = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Async reset while DONE: MFC drops immediately
    load_mar(16'h0003);
    run_access(1'b1, lat);
    chk("t6_rd_latency", lat, 3);
    #2 rst = 1'b1;
    #1 chk("t6_rst_mfc_done", MFC, 1'b0);
    memEN = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    read_word("t6_rd2_latency", 16'h0007, val);
    chk("t6_target_unchanged", val, 16'hAAAA);

    // WAIT_CYCLES=0 build
    z_bus_in = 16'h0001; z_marIn = 1'b1;
    tick();
    z_marIn = 1'b0; z_bus_in = 16'h0F0F; z_mdrWriteEN = 1'b1;
    tick();
    z_mdrWriteEN = 1'b0; z_memEN = 1'b1; z_RW = 1'b0;
    tick();
    chk("t7_mfc_at_e0", z_MFC, 1'b0);
    tick();
    chk("t7_mfc_e0_plus1", z_MFC, 1'b1);
    z_memEN = 1'b0;
    tick();
    chk("t7_mfc_fall", z_MFC, 1'b0);
    z_memEN = 1'b1; z_RW = 1'b1;
    tick();
    tick();
    chk("t7_rd_mfc", z_MFC, 1'b1);
    z_mdrReadEN = 1'b1; z_memEN = 1'b0;
    tick();
    z_mdrReadEN = 1'b0; z_mdrOut = 1'b1;
    #1;
    chk("t7_read_data", z_bus_out, 16'h0F0F);
    chk("t7_bus_drive", z_bus_drive, 1'b1);
    z_mdrOut = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
